weight_loader_18_9_42_2: RTL



---
 rtl/weight_loader_18_9_42_2_pkg.sv | 11 +
 rtl/weight_loader_18_9_42_2_weight_packer.sv | 27 ++
 rtl/weight_loader_18_9_42_2.sv | 88 ++++++++
 3 files changed

// File: rtl/weight_loader_18_9_42_2_pkg.sv
// weight_loader_18_9_42_2_pkg: geometry constants and FSM states shared by the loader and the read-side weight buffer.
package weight_loader_18_9_42_2_pkg;
    localparam int DATA_WIDTH  = 18;
    localparam int LANES       = 9;
    localparam int ROWS        = 42;
    localparam int BANKS       = 2;
    localparam int ADDR_WIDTH  = 12;
    localparam int BANK_STRIDE = 42;
    localparam int WORD_WIDTH  = DATA_WIDTH * LANES;
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;
endpackage

// File: rtl/weight_loader_18_9_42_2_weight_packer.sv
// weight_loader_18_9_42_2_weight_packer: right-shifting pack register and lane counter; word_o is the word as it will look after this accept.
module weight_loader_18_9_42_2_weight_packer
    import weight_loader_18_9_42_2_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_valid_o
);
    localparam int LW = $clog2(LANES);
    logic [LW-1:0]                    lane_q;
    // Only the eight oldest lanes need storing; the ninth arrives on the completing accept.
    logic [WORD_WIDTH-DATA_WIDTH-1:0] pack_q;
    assign word_o       = {data_i, pack_q};
    assign word_valid_o = accept_i && lane_q == LW'(LANES - 1);
    always_ff @(posedge clk)
        if (reset || clear_i) begin
            lane_q <= '0;
            pack_q <= '0;
        end else if (accept_i) begin
            lane_q <= word_valid_o ? '0 : lane_q + 1'b1;
            pack_q <= word_o[WORD_WIDTH-1:DATA_WIDTH];
        end
endmodule

// File: rtl/weight_loader_18_9_42_2.sv
// weight_loader_18_9_42_2: streams weights into packed words and writes them bank-major into two weight RAMs.
// Optional running checksum output enabled by defining WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader_18_9_42_2
    import weight_loader_18_9_42_2_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  wr_en_0,
    output logic                  wr_en_1,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);
    localparam int RW = $clog2(ROWS);
    localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
    state_t                state_q, state_d;
    logic [RW-1:0]         row_q;
    logic [BW-1:0]         bank_q;
    logic [BANKS-1:0]      wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [WORD_WIDTH-1:0] wr_data_q, word;
    logic                  accept, start_ok, word_valid, last;
    assign accept   = in_valid && in_ready;
    assign start_ok = state_q == IDLE && start;
    assign last     = word_valid && row_q == RW'(ROWS - 1) && bank_q == BW'(BANKS - 1);
    weight_loader_18_9_42_2_weight_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start_ok),
        .accept_i     (accept),
        .data_i       (in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );
    always_ff @(posedge clk)
        state_q <= reset ? IDLE : state_d;
    always_comb
        state_d = start_ok                   ? LOAD  :
                  (state_q == LOAD && last)  ? FLUSH :
                  (state_q == FLUSH)         ? IDLE  : state_q;
    always_comb begin
        in_ready = state_q == LOAD;
        busy     = state_q != IDLE;
        done     = state_q == FLUSH;
    end
    always_ff @(posedge clk)
        if (reset) begin
            row_q     <= '0;
            bank_q    <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= '0;
            if (start_ok) begin
                row_q  <= '0;
                bank_q <= '0;
            end else if (word_valid) begin
                row_q     <= row_q == RW'(ROWS - 1) ? '0 : row_q + 1'b1;
                bank_q    <= row_q == RW'(ROWS - 1) ? bank_q + 1'b1 : bank_q;
                wr_en_q   <= BANKS'(1) << bank_q;
                wr_addr_q <= ADDR_WIDTH'(row_q) + ADDR_WIDTH'(bank_q) * ADDR_WIDTH'(BANK_STRIDE);
                wr_data_q <= word;
            end
        end
    assign wr_en_0 = wr_en_q[0];
    assign wr_en_1 = wr_en_q[1];
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;
    always_ff @(posedge clk)
        if (reset || start_ok)
            checksum_q <= '0;
        else if (accept)
            checksum_q <= checksum_q + in_data;
    assign checksum = checksum_q;
`endif
endmodule
